apb_top: RTL and testbench
==========================

APB_TOP -- requirements
Module: apb_top

Interface
REQ-001 Parameter ADDR_W, default 32, AHB/APB address width.
REQ-002 Parameter DATA_W, default 32, AHB/APB data width.
REQ-003 hclk  input  1  single clock; all state changes on its rising edge.
REQ-004 hreset_n  input  1  asynchronous, active-low reset.
REQ-005 hsel  input  1  AHB slave select.
REQ-006 haddr  input  ADDR_W  AHB address.
REQ-007 htrans  input  2  AHB transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 hwrite  input  1  1 = write, 0 = read.
REQ-009 hsize/hburst  input  3/3  accepted; word transfers only; otherwise ignored.
REQ-010 hwdata  input  DATA_W  AHB write data, valid in the data phase.
REQ-011 hready  input  1  AHB bus ready, qualifying the address phase.
REQ-012 hreadyout  output  1  slave ready; 0 inserts wait states.
REQ-013 hresp  output  1  0 = OKAY, 1 = ERROR.
REQ-014 hrdata  output  DATA_W  AHB read data.
REQ-015 paddr  output  ADDR_W  APB address.
REQ-016 psel, penable, pwrite  output  1 each  APB control.
REQ-017 pwdata  output  DATA_W  APB write data.
REQ-018 prdata  input  DATA_W  APB read data.
REQ-019 pready, pslverr  input  1 each  APB completion and error.

Function
REQ-020 A transfer SHALL be accepted on a rising edge where hsel=1, hready=1 and htrans[1]=1.
REQ-021 On acceptance the block SHALL register haddr and hwrite, and the FSM SHALL move from IDLE to SETUP.
REQ-022 IDLE or BUSY htrans, or hsel=0, SHALL cause no APB activity, with hreadyout=1 and hresp=0.
REQ-023 FSM states SHALL be IDLE, SETUP, ACCESS, ERR1 and ERR2.
REQ-024 SETUP SHALL last exactly 1 cycle: psel=1, penable=0, paddr and pwrite from the registers, hreadyout=0.
REQ-025 In SETUP, pwdata SHALL equal hwdata and SHALL be registered at the end of SETUP, then held through ACCESS.
REQ-026 ACCESS SHALL drive psel=1, penable=1 and hreadyout=pready (combinational), with paddr, pwrite and pwdata stable.
REQ-027 ACCESS SHALL repeat while pready=0, giving one added AHB wait state per cycle.
REQ-028 In ACCESS, when pready=1 and pslverr=0: hresp=0, and for a read hrdata=prdata in the same cycle.
REQ-029 On successful completion the next state SHALL be SETUP if a new transfer is accepted in that same cycle (pipelined address phase), else IDLE.
REQ-030 In ACCESS, pready=1 with pslverr=1 SHALL force hreadyout=0 and hresp=1, and go to ERR1.
REQ-031 ERR1 SHALL drive hreadyout=0, hresp=1, psel=0, then go to ERR2.
REQ-032 ERR2 SHALL drive hreadyout=1, hresp=1, then go to IDLE; an address phase accepted in ERR2 SHALL go to SETUP.
REQ-033 Minimum AHB data phase SHALL be 2 cycles (SETUP plus ACCESS with pready=1).
REQ-034 Each accepted AHB transfer SHALL produce exactly 1 APB transfer, in order, with no loss or duplication.
REQ-035 hrdata SHALL hold its last value outside read completion.
REQ-036 Outside SETUP and ACCESS, psel=0 and penable=0.

Reset
REQ-037 While hreset_n=0: state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hresp=0, hreadyout=1.
REQ-038 Reset asserted mid-transfer SHALL abort immediately with no completion response.

Verification
REQ-039 Hold hreset_n=0 for 205 ns at a 20 ns hclk -> all outputs equal the REQ-037 values throughout.
REQ-040 NONSEQ write, haddr=0x0000_0010, hwdata=0xA5A5_5A5A, pready=1 -> one SETUP then one ACCESS with paddr=0x10, pwrite=1 and pwdata=0xA5A5_5A5A; hreadyout=0 for 1 cycle only.
REQ-041 Read of 0x0000_002C, pready low for 3 ACCESS cycles, prdata=0x1234_5678 -> hreadyout=0 for 4 cycles, then hrdata=0x1234_5678 with hreadyout=1.
REQ-042 5 writes starting at index 11 (haddr=11*4 upward), with 0-3 random idle cycles between them, plus a back-to-back pipelined pair -> exactly 5 APB writes with matching addresses and data, in order.
REQ-043 Write with pslverr=1 at completion -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE.
REQ-044 htrans=IDLE or BUSY with hsel=1 -> psel stays 0 and hreadyout stays 1.

Source files
------------

// File: rtl/apb_top.sv
// AHB-Lite to APB bridge: each accepted AHB word transfer becomes one APB transfer.
// pready stretches the AHB data phase; pslverr returns a two-cycle AHB ERROR.
module apb_top #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept_c;
  logic              load_c;
  logic              rd_done_c;

  // Only word transfers exist, so size/burst and the SEQ/NONSEQ distinction carry no information
  logic ctrl_unused;
  assign ctrl_unused = ^{hsize, hburst, htrans[0]};

  assign accept_c  = hsel & hready & htrans[1];
  assign rd_done_c = (state_q == S_ACCESS) & pready & ~pslverr & ~write_q;

  // Next state, APB strobes and AHB response
  always_comb begin
    state_d   = state_q;
    load_c    = 1'b0;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_SETUP;
          load_c  = 1'b1;
        end
      end
      S_SETUP: begin
        psel      = 1'b1;
        hreadyout = 1'b0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        hreadyout = pready & ~pslverr;
        if (pready) begin
          if (pslverr) begin
            hresp   = 1'b1;
            state_d = S_ERR1;
          end else if (accept_c) begin
            state_d = S_SETUP;
            load_c  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        hresp = 1'b1;
        if (accept_c) begin
          state_d = S_SETUP;
          load_c  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State plus address-phase, write-data and read-data capture
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        addr_q  <= haddr;
        write_q <= hwrite;
      end
      if (state_q == S_SETUP) wdata_q <= hwdata;
      if (rd_done_c) rdata_q <= prdata;
    end
  end

  assign paddr  = addr_q;
  assign pwrite = write_q;
  // hwdata is only valid in the AHB data phase, so SETUP passes it through before it is captured
  assign pwdata = (state_q == S_SETUP) ? hwdata : wdata_q;
  assign hrdata = rd_done_c ? prdata : rdata_q;

endmodule

// File: tb/tb_apb_top.sv
// Randomized bench for apb_top: AHB master driver, APB slave responder and a
// transaction-level scoreboard of expected APB transfers and AHB responses.
module tb_apb_top;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned CYC_MAX = 4000;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int unsigned   wait_n;
    logic          err;
    int unsigned   gap;
  } op_t;

  logic          hclk = 1'b0;
  logic          hreset_n = 1'b1;
  logic          hsel = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic [1:0]    htrans = 2'b00;
  logic          hwrite = 1'b0;
  logic [2:0]    hsize = 3'd2;
  logic [2:0]    hburst = 3'd0;
  logic [DW-1:0] hwdata = '0;
  logic          hready;
  logic          hreadyout, hresp;
  logic [DW-1:0] hrdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  op_t           ops[$];
  op_t           slv_q[$];
  op_t           exp_q[$];
  bit            mon_en = 1'b0;
  int unsigned   err_ph = 0;
  logic [DW-1:0] last_rd = '0;
  int unsigned   apb_wr_done = 0;
  bit            setup_prev = 1'b0;

  // Single-slave system: the bus ready is the slave's own ready
  assign hready = hreadyout;

  apb_top #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #10 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic op_t mk_op(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                                input logic [DW-1:0] rd, input int unsigned wt, input logic er,
                                input int unsigned gp);
    op_t o;
    o.addr = a; o.write = w; o.wdata = wd; o.rdata = rd;
    o.wait_n = wt; o.err = er; o.gap = gp;
    return o;
  endfunction

  task automatic drive_idle();
    hsel   = 1'($urandom);
    htrans = {1'b0, 1'($urandom)};
    haddr  = $urandom;
    hwrite = 1'($urandom);
    hburst = 3'($urandom);
  endtask

  // APB slave: wait_n low-pready ACCESS cycles, then complete with the op's error/read data
  op_t         s_cur;
  int unsigned s_cnt = 0;
  always @(posedge hclk) begin
    #1;
    if (psel && !penable) begin
      if (slv_q.size() != 0) s_cur = slv_q.pop_front();
      else s_cur = mk_op('0, 1'b0, '0, '0, 0, 1'b0, 0);
      s_cnt   = s_cur.wait_n;
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = $urandom;
    end else if (psel && penable) begin
      pready  = (s_cnt == 0);
      pslverr = pready && s_cur.err;
      prdata  = pready ? s_cur.rdata : $urandom;
      if (s_cnt != 0) s_cnt--;
    end else begin
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
    end
  end

  // Scoreboard: APB transfers in order, AHB response per phase, hrdata holding
  op_t e;
  bit  rd_done;
  always @(negedge hclk) begin
    if (mon_en) begin
      rd_done = 1'b0;
      if (setup_prev) check("setup_then_access", 32'(psel && penable), 32'd1);
      if (psel && !penable) begin
        check("setup_hreadyout", 32'(hreadyout), 32'd0);
        check("setup_pwdata", pwdata, hwdata);
      end else if (psel && penable) begin
        if (pready) begin
          check("apb_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("paddr", paddr, e.addr);
            check("pwrite", 32'(pwrite), 32'(e.write));
            if (e.write) check("pwdata", pwdata, e.wdata);
            check("done_hreadyout", 32'(hreadyout), 32'(!e.err));
            check("done_hresp", 32'(hresp), 32'(e.err));
            if (e.err) begin
              err_ph = 1;
            end else if (e.write) begin
              apb_wr_done++;
            end else begin
              check("hrdata", hrdata, e.rdata);
              last_rd = e.rdata;
              rd_done = 1'b1;
            end
          end
        end else begin
          check("wait_hreadyout", 32'(hreadyout), 32'd0);
          check("wait_hresp", 32'(hresp), 32'd0);
        end
      end else begin
        check("idle_penable", 32'(penable), 32'd0);
        if (err_ph == 1) begin
          check("err1_hreadyout", 32'(hreadyout), 32'd0);
          check("err1_hresp", 32'(hresp), 32'd1);
          err_ph = 2;
        end else if (err_ph == 2) begin
          check("err2_hreadyout", 32'(hreadyout), 32'd1);
          check("err2_hresp", 32'(hresp), 32'd1);
          err_ph = 0;
        end else begin
          check("idle_hreadyout", 32'(hreadyout), 32'd1);
          check("idle_hresp", 32'(hresp), 32'd0);
        end
      end
      if (!rd_done) check("hrdata_hold", hrdata, last_rd);
      setup_prev = psel && !penable;
    end
  end

  // AHB master: runs the ops queue; gap 0 pipelines behind the previous data phase,
  // gap N waits N idle cycles after it completes. Starts and ends at posedge+1.
  task automatic run_ops();
    int  n = ops.size();
    int  nxt = 0, dat = -1, cur = -1;
    int unsigned idle_cnt = 0, cyc = 0, wcnt = 0;
    bit  pres = 1'b0;
    bit  rdy;
    while ((nxt < n || dat >= 0 || pres) && cyc < CYC_MAX) begin
      if (!pres && nxt < n && (ops[nxt].gap == 0 || (dat < 0 && idle_cnt >= ops[nxt].gap))) begin
        pres = 1'b1; cur = nxt; nxt++;
        hsel = 1'b1; htrans = 2'b10; haddr = ops[cur].addr; hwrite = ops[cur].write;
        hsize = 3'd2; hburst = 3'($urandom);
        slv_q.push_back(ops[cur]);
        exp_q.push_back(ops[cur]);
      end else if (!pres) begin
        drive_idle();
        if (dat < 0) idle_cnt++;
      end
      hwdata = (dat >= 0) ? ops[dat].wdata : DW'($urandom);
      @(negedge hclk);
      rdy = hreadyout;
      @(posedge hclk);
      #1;
      cyc++;
      if (dat >= 0 && !rdy) wcnt++;
      if (rdy) begin
        if (dat >= 0) begin
          check("data_phase_waits", 32'(wcnt), 32'(ops[dat].wait_n + 1 + (ops[dat].err ? 2 : 0)));
          idle_cnt = 0;
        end
        dat  = -1;
        wcnt = 0;
        if (pres) begin
          dat  = cur;
          pres = 1'b0;
        end
      end
    end
    check("run_ops_in_budget", 32'(cyc < CYC_MAX), 32'd1);
    drive_idle();
    ops.delete();
  endtask

  int unsigned wr_before;

  initial begin
    // Reset held for 205 ns with an active-looking bus
    #1 hreset_n = 1'b0;
    repeat (10) begin
      hsel = 1'b1; htrans = 2'b10; haddr = $urandom; hwrite = 1'b1; hwdata = $urandom;
      @(negedge hclk);
      check("rst_psel", 32'(psel), 32'd0);
      check("rst_penable", 32'(penable), 32'd0);
      check("rst_pwrite", 32'(pwrite), 32'd0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_hrdata", hrdata, 32'd0);
      check("rst_hresp", 32'(hresp), 32'd0);
      check("rst_hreadyout", 32'(hreadyout), 32'd1);
    end
    drive_idle();
    #6 hreset_n = 1'b1;
    @(posedge hclk);
    #1 mon_en = 1'b1;

    // Single zero-wait write
    ops.push_back(mk_op(32'h0000_0010, 1'b1, 32'hA5A5_5A5A, '0, 0, 1'b0, 1));
    run_ops();
    // Read with three wait states
    ops.push_back(mk_op(32'h0000_002C, 1'b0, $urandom, 32'h1234_5678, 3, 1'b0, 2));
    run_ops();

    // Five writes from word index 11, random gaps, one forced pipelined pair
    wr_before = apb_wr_done;
    for (int i = 0; i < 5; i++)
      ops.push_back(mk_op(AW'((11 + i) * 4), 1'b1, $urandom, '0, $urandom_range(0, 2), 1'b0,
                          (i == 3) ? 0 : $urandom_range(1, 3)));
    run_ops();
    check("five_writes", apb_wr_done - wr_before, 32'd5);

    // Error response, then idle; then error with a transfer accepted in ERR2
    ops.push_back(mk_op(32'h0000_0040, 1'b1, $urandom, '0, 1, 1'b1, 1));
    ops.push_back(mk_op(32'h0000_0044, 1'b0, $urandom, $urandom, 0, 1'b0, 2));
    ops.push_back(mk_op(32'h0000_0048, 1'b0, $urandom, $urandom, 0, 1'b1, 1));
    ops.push_back(mk_op(32'h0000_004C, 1'b1, $urandom, '0, 2, 1'b0, 0));
    run_ops();

    // Selected IDLE/BUSY cycles never start an APB transfer
    for (int i = 0; i < 8; i++) begin
      hsel = 1'b1; htrans = 2'(i % 2); haddr = $urandom; hwrite = 1'($urandom);
      @(negedge hclk);
      check("idlebusy_psel", 32'(psel), 32'd0);
      check("idlebusy_hreadyout", 32'(hreadyout), 32'd1);
      @(posedge hclk);
      #1;
    end
    drive_idle();

    // Random traffic
    for (int i = 0; i < 40; i++)
      ops.push_back(mk_op(32'($urandom) & 32'hFFFF_FFFC, 1'($urandom), $urandom, $urandom,
                          $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                          $urandom_range(0, 3)));
    run_ops();

    // Reset asserted in the middle of an ACCESS wait
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0080; hwrite = 1'b0;
    slv_q.push_back(mk_op(32'h0000_0080, 1'b0, '0, $urandom, 8, 1'b0, 0));
    @(posedge hclk);
    #1 drive_idle();
    @(posedge hclk);
    @(negedge hclk);
    check("abort_in_access", 32'(psel && penable), 32'd1);
    #3;
    mon_en = 1'b0;
    hreset_n = 1'b0;
    #1;
    check("abort_psel", 32'(psel), 32'd0);
    check("abort_penable", 32'(penable), 32'd0);
    check("abort_hreadyout", 32'(hreadyout), 32'd1);
    check("abort_hresp", 32'(hresp), 32'd0);
    check("abort_paddr", paddr, 32'd0);
    check("abort_hrdata", hrdata, 32'd0);
    slv_q.delete();
    exp_q.delete();
    last_rd = '0;
    err_ph = 0;
    setup_prev = 1'b0;
    @(negedge hclk);
    #5 hreset_n = 1'b1;
    @(posedge hclk);
    #1 mon_en = 1'b1;

    // Recovery after the abort
    ops.push_back(mk_op(32'h0000_0100, 1'b1, $urandom, '0, 1, 1'b0, 1));
    ops.push_back(mk_op(32'h0000_0104, 1'b0, $urandom, $urandom, 0, 1'b0, 0));
    run_ops();
    repeat (3) @(posedge hclk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("slv_q_drained", 32'(slv_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
